// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one memory port among NUM_PB requesters,
// with optional locked bursts and a read-return routing pipeline.
module mem_arbiter #(
  parameter int unsigned NUM_PB       = 8,
  parameter int unsigned ADDR_WIDTH   = 16,
  parameter int unsigned DATA_WIDTH   = 512,
  parameter int unsigned READ_LATENCY = 1,
  parameter int unsigned MAX_BURST    = 4
) (
  input  logic                         clock,
  input  logic                         reset_n,
  input  logic [NUM_PB-1:0]            req_valid,
  input  logic [NUM_PB-1:0]            req_write,
  input  logic [NUM_PB-1:0]            req_lock,
  input  logic [NUM_PB*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_PB*DATA_WIDTH-1:0] req_wdata,
  output logic [NUM_PB-1:0]            req_ready,
  output logic                         mem_re,
  output logic                         mem_we,
  output logic [ADDR_WIDTH-1:0]        mem_addr,
  output logic [DATA_WIDTH-1:0]        mem_wdata,
  input  logic [DATA_WIDTH-1:0]        mem_rdata,
  output logic [NUM_PB-1:0]            rsp_valid,
  output logic [DATA_WIDTH-1:0]        rsp_data
);

  localparam int unsigned ID_W  = (NUM_PB > 1) ? $clog2(NUM_PB) : 1;
  localparam int unsigned CNT_W = $clog2(MAX_BURST + 1);

  typedef enum logic {ARB, OWN} state_t;

  state_t            state;
  logic [ID_W-1:0]   owner;
  logic [ID_W-1:0]   rr_ptr;
  logic [CNT_W-1:0]  beat_cnt;

  logic [ID_W-1:0]   grant_id;
  logic [ID_W-1:0]   rr_next;
  logic [ID_W-1:0]   cand;
  int unsigned       idx;
  logic              accept;
  logic              burst_end;

  logic              pipe_vld [READ_LATENCY];
  logic [ID_W-1:0]   pipe_id  [READ_LATENCY];

  // Grant selection: owner only while locked, otherwise first requester from rr_ptr
  always_comb begin
    req_ready = '0;
    grant_id  = '0;
    accept    = 1'b0;
    idx       = 0;
    cand      = '0;
    if (reset_n) begin
      if (state == OWN) begin
        if (req_valid[owner]) begin
          req_ready[owner] = 1'b1;
          grant_id         = owner;
          accept           = 1'b1;
        end
      end else begin
        for (int unsigned k = 0; k < NUM_PB; k++) begin
          idx  = (32'(rr_ptr) + k) % NUM_PB;
          cand = ID_W'(idx);
          if (!accept && req_valid[cand]) begin
            req_ready[cand] = 1'b1;
            grant_id        = cand;
            accept          = 1'b1;
          end
        end
      end
    end
  end

  // Pointer advance and burst termination decode
  always_comb begin
    rr_next   = ID_W'((32'(grant_id) + 1) % NUM_PB);
    burst_end = !req_lock[owner] || ((32'(beat_cnt) + 1) >= MAX_BURST);
  end

  // Ownership FSM, round-robin pointer and burst counter
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state    <= ARB;
      owner    <= '0;
      rr_ptr   <= '0;
      beat_cnt <= '0;
    end else begin
      case (state)
        ARB: begin
          if (accept) begin
            rr_ptr <= rr_next;
            if (req_lock[grant_id] && (MAX_BURST > 1)) begin
              state    <= OWN;
              owner    <= grant_id;
              beat_cnt <= CNT_W'(1);
            end
          end
        end
        OWN: begin
          if (!accept) begin
            state    <= ARB;
            beat_cnt <= '0;
          end else begin
            rr_ptr <= rr_next;
            if (burst_end) begin
              state    <= ARB;
              beat_cnt <= '0;
            end else begin
              beat_cnt <= beat_cnt + CNT_W'(1);
            end
          end
        end
        default: state <= ARB;
      endcase
    end
  end

  // Registered memory controls; address and data hold when idle
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      mem_re    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      mem_re <= accept && !req_write[grant_id];
      mem_we <= accept && req_write[grant_id];
      if (accept) begin
        mem_addr  <= req_addr[32'(grant_id)*ADDR_WIDTH +: ADDR_WIDTH];
        mem_wdata <= req_wdata[32'(grant_id)*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Read-return pipeline: requester id travels alongside the memory latency
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned j = 0; j < READ_LATENCY; j++) begin
        pipe_vld[j] <= 1'b0;
        pipe_id[j]  <= '0;
      end
      rsp_valid <= '0;
    end else begin
      pipe_vld[0] <= accept && !req_write[grant_id];
      pipe_id[0]  <= grant_id;
      for (int unsigned j = 1; j < READ_LATENCY; j++) begin
        pipe_vld[j] <= pipe_vld[j-1];
        pipe_id[j]  <= pipe_id[j-1];
      end
      rsp_valid <= pipe_vld[READ_LATENCY-1] ?
                   (NUM_PB'(1) << pipe_id[READ_LATENCY-1]) : '0;
    end
  end

  assign rsp_data = mem_rdata;

endmodule
